facto_master: RTL and testbench

- Bus-master sequencer that drives the FactoCore slave register interface on behalf of a client.
- Accepts one operand per request and issues the full register sequence: opclear pulse, operand write, interrupt enable, opstart.
- Waits for interrupt, then reads result_h and result_l and returns the 128-bit factorial result on a valid/ready response channel.
- Sits between a client datapath and FactoCore; it is the initiator end of the same slave bus.

---
 rtl/facto_pkg.sv | 29 ++
 rtl/facto_master_if.sv | 41 ++++
 rtl/facto_bus_drv.sv | 52 +++++
 rtl/facto_master.sv | 110 +++++++++++
 tb/tb_facto_master.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/facto_pkg.sv
// FactoCore register map, sequencer state encoding and shared defaults.
package facto_pkg;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 16;

    localparam logic [ADDR_W-1:0] OFS_OPSTART  = 16'h0000;
    localparam logic [ADDR_W-1:0] OFS_OPCLEAR  = 16'h0008;
    localparam logic [ADDR_W-1:0] OFS_INTREN   = 16'h0018;
    localparam logic [ADDR_W-1:0] OFS_OPERAND  = 16'h0020;
    localparam logic [ADDR_W-1:0] OFS_RESULT_H = 16'h0028;
    localparam logic [ADDR_W-1:0] OFS_RESULT_L = 16'h0030;

    localparam int TIMEOUT_CYCLES_DEF = 4096;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLR1,
        ST_CLR0,
        ST_WOPND,
        ST_WIEN,
        ST_WSTART,
        ST_WAIT,
        ST_RDH,
        ST_RDL,
        ST_RESP,
        ST_TCLR1,
        ST_TCLR0
    } state_t;
endpackage

// File: rtl/facto_master_if.sv
// Client request/response channel plus the FactoCore slave bus.
// rsp_timeout exists only when FACTO_MASTER_TIMEOUT_EN is defined.
interface facto_master_if;
    import facto_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_operand;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result_h;
    logic [DATA_W-1:0] rsp_result_l;
    logic              busy;
`ifdef FACTO_MASTER_TIMEOUT_EN
    logic              rsp_timeout;
`endif
    logic              m_sel;
    logic              m_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_dout;
    logic [DATA_W-1:0] m_din;
    logic              interrupt;

    modport master (
        input  req_valid, req_operand, rsp_ready, m_din, interrupt,
        output req_ready, rsp_valid, rsp_result_h, rsp_result_l, busy,
`ifdef FACTO_MASTER_TIMEOUT_EN
        output rsp_timeout,
`endif
        output m_sel, m_wr, m_addr, m_dout
    );

    modport slave (
        output req_valid, req_operand, rsp_ready, m_din, interrupt,
        input  req_ready, rsp_valid, rsp_result_h, rsp_result_l, busy,
`ifdef FACTO_MASTER_TIMEOUT_EN
        input  rsp_timeout,
`endif
        input  m_sel, m_wr, m_addr, m_dout
    );
endinterface

// File: rtl/facto_bus_drv.sv
// Registered bus issuer: decodes the state being entered into one FactoCore
// bus cycle so the bus pins line up with the sequencer state register.
module facto_bus_drv
    import facto_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h7000
) (
    input  logic              clk,
    input  logic              reset,
    input  state_t            state,
    input  logic [DATA_W-1:0] operand,
    output logic              sel,
    output logic              wr,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] dout
);
    logic              sel_d;
    logic              wr_d;
    logic [ADDR_W-1:0] ofs_d;
    logic [DATA_W-1:0] dout_d;

    always_comb begin
        sel_d  = 1'b0;
        wr_d   = 1'b0;
        ofs_d  = '0;
        dout_d = '0;
        case (state)
            ST_CLR1, ST_TCLR1: begin sel_d = 1'b1; wr_d = 1'b1; ofs_d = OFS_OPCLEAR; dout_d = DATA_W'(1); end
            ST_CLR0, ST_TCLR0: begin sel_d = 1'b1; wr_d = 1'b1; ofs_d = OFS_OPCLEAR; end
            ST_WOPND:  begin sel_d = 1'b1; wr_d = 1'b1; ofs_d = OFS_OPERAND; dout_d = operand; end
            ST_WIEN:   begin sel_d = 1'b1; wr_d = 1'b1; ofs_d = OFS_INTREN;  dout_d = DATA_W'(1); end
            ST_WSTART: begin sel_d = 1'b1; wr_d = 1'b1; ofs_d = OFS_OPSTART; dout_d = DATA_W'(1); end
            ST_RDH:    begin sel_d = 1'b1; ofs_d = OFS_RESULT_H; end
            ST_RDL:    begin sel_d = 1'b1; ofs_d = OFS_RESULT_L; end
            default:   ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel  <= 1'b0;
            wr   <= 1'b0;
            addr <= '0;
            dout <= '0;
        end else begin
            sel  <= sel_d;
            wr   <= wr_d;
            addr <= sel_d ? (BASE_ADDR + ofs_d) : '0;
            dout <= dout_d;
        end
    end
endmodule

// File: rtl/facto_master.sv
// FactoCore bus master: runs clear/operand/enable/start, waits for the
// interrupt, reads the 128-bit result back. Optional WAIT timeout with abort
// is compiled in by FACTO_MASTER_TIMEOUT_EN.
module facto_master
    import facto_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR      = 16'h7000,
    parameter int                TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic           clk,
    input  logic           reset,
    facto_master_if.master bus
);
    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] operand_q;
    logic [DATA_W-1:0] result_h;
    logic [DATA_W-1:0] result_l;
    logic              rsp_valid_q;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("facto_master: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef FACTO_MASTER_TIMEOUT_EN
    logic [31:0] wait_cnt;
    logic        timeout_q;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (bus.req_valid) state_nxt = ST_CLR1;
            ST_CLR1:   state_nxt = ST_CLR0;
            ST_CLR0:   state_nxt = ST_WOPND;
            ST_WOPND:  state_nxt = ST_WIEN;
            ST_WIEN:   state_nxt = ST_WSTART;
            ST_WSTART: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (bus.interrupt) state_nxt = ST_RDH;
`ifdef FACTO_MASTER_TIMEOUT_EN
                else if (wait_cnt == 32'(TIMEOUT_CYCLES - 1)) state_nxt = ST_TCLR1;
`endif
            end
            ST_RDH:    state_nxt = ST_RDL;
            ST_RDL:    state_nxt = ST_RESP;
            ST_TCLR1:  state_nxt = ST_TCLR0;
            ST_TCLR0:  state_nxt = ST_RESP;
            ST_RESP:   if (bus.rsp_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Slave reads are combinational, so m_din is captured on the edge ending RDH/RDL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            operand_q   <= '0;
            result_h    <= '0;
            result_l    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            rsp_valid_q <= (state_nxt == ST_RESP);
            if (state == ST_IDLE && bus.req_valid) operand_q <= bus.req_operand;
            if (state == ST_RDH) result_h <= bus.m_din;
            if (state == ST_RDL) result_l <= bus.m_din;
`ifdef FACTO_MASTER_TIMEOUT_EN
            if (state == ST_TCLR1) begin
                result_h <= '0;
                result_l <= '0;
            end
`endif
        end
    end

`ifdef FACTO_MASTER_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + 32'd1 : 32'd0;
            if (state == ST_TCLR0) timeout_q <= 1'b1;
            else if (state == ST_RESP && bus.rsp_ready) timeout_q <= 1'b0;
        end
    end

    assign bus.rsp_timeout = timeout_q;
`endif

    facto_bus_drv #(
        .BASE_ADDR (BASE_ADDR)
    ) u_bus_drv (
        .clk     (clk),
        .reset   (reset),
        .state   (state_nxt),
        .operand (operand_q),
        .sel     (bus.m_sel),
        .wr      (bus.m_wr),
        .addr    (bus.m_addr),
        .dout    (bus.m_dout)
    );

    assign bus.req_ready    = (state == ST_IDLE);
    assign bus.busy         = (state != ST_IDLE);
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_result_h = result_h;
    assign bus.rsp_result_l = result_l;
endmodule

// File: tb/tb_facto_master.sv
// Bench for facto_master: behavioural FactoCore slave, bus-trace and latency
// reference model, table vectors, random operations and reset/timeout sequences.
`timescale 1ns/1ps
module tb_facto_master;
    localparam int TO_CYCLES = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    facto_master_if bus_if();

    facto_master #(
        .BASE_ADDR      (16'h7000),
        .TIMEOUT_CYCLES (TO_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] fact128(input logic [63:0] n);
        logic [127:0] r;
        r = 128'd1;
        for (int i = 2; i <= int'(n); i++) r = r * 128'(i);
        return r;
    endfunction

    // Slave raises its interrupt d cycles after the opstart cycle; WAIT is
    // entered 5 edges after accept and only samples from the following edge.
    function automatic int exp_latency(input int d);
        int sample;
        sample = (5 + d > 6) ? 5 + d : 6;
        return sample + 2;
    endfunction

    // ---------------- behavioural FactoCore slave ----------------
    int           irq_delay = 0;
    logic [63:0]  s_operand = '0;
    logic         s_ien = 1'b0;
    logic         s_irq = 1'b0;
    logic [127:0] s_result = '0;
    int           s_cnt = 0;

    always @(negedge clk) begin
        if (bus_if.m_sel && bus_if.m_wr) begin
            case (bus_if.m_addr)
                16'h7008: if (bus_if.m_dout[0]) begin s_irq <= 1'b0; s_cnt <= 0; s_result <= '0; end
                16'h7018: s_ien <= bus_if.m_dout[0];
                16'h7020: s_operand <= bus_if.m_dout;
                16'h7000: if (bus_if.m_dout[0]) begin
                    s_result <= fact128(s_operand);
                    if (irq_delay == 0) s_irq <= s_ien;
                    else s_cnt <= (irq_delay < 0) ? 0 : irq_delay;
                end
                default: ;
            endcase
        end else if (s_cnt > 0) begin
            s_cnt <= s_cnt - 1;
            if (s_cnt == 1) s_irq <= s_ien;
        end
    end

    assign bus_if.interrupt = s_irq;
    assign bus_if.m_din = (bus_if.m_addr == 16'h7028) ? s_result[127:64] :
                          (bus_if.m_addr == 16'h7030) ? s_result[63:0] : 64'd0;

    // ---------------- bus monitor ----------------
    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [63:0] data;
    } bus_rec_t;
    bus_rec_t trace[$];

    always @(negedge clk) if (bus_if.m_sel) trace.push_back({bus_if.m_wr, bus_if.m_addr, bus_if.m_dout});

    task automatic check_trace(input string tag, input logic [63:0] n, input bit timed_out);
        bus_rec_t exp[$];
        exp.push_back('{1'b1, 16'h7008, 64'd1});
        exp.push_back('{1'b1, 16'h7008, 64'd0});
        exp.push_back('{1'b1, 16'h7020, n});
        exp.push_back('{1'b1, 16'h7018, 64'd1});
        exp.push_back('{1'b1, 16'h7000, 64'd1});
        if (timed_out) begin
            exp.push_back('{1'b1, 16'h7008, 64'd1});
            exp.push_back('{1'b1, 16'h7008, 64'd0});
        end else begin
            exp.push_back('{1'b0, 16'h7028, 64'd0});
            exp.push_back('{1'b0, 16'h7030, 64'd0});
        end
        chk({tag, " trace_len"}, 128'(trace.size()), 128'(exp.size()));
        for (int i = 0; i < exp.size() && i < trace.size(); i++) begin
            chk($sformatf("%s trace[%0d] wr/addr", tag, i),
                128'({trace[i].wr, trace[i].addr}), 128'({exp[i].wr, exp[i].addr}));
            if (exp[i].wr) chk($sformatf("%s trace[%0d] data", tag, i), 128'(trace[i].data), 128'(exp[i].data));
        end
    endtask

    task automatic do_op(input string tag, input logic [63:0] n, input int d, input int hold,
                         input logic [127:0] exp_res, input int exp_lat, input bit exp_to);
        int guard;
        int lat;
        irq_delay = d;
        guard = 0;
        while (!bus_if.req_ready && guard < 50) begin @(negedge clk); guard++; end
        chk({tag, " req_ready before"}, 128'(bus_if.req_ready), 128'(1));
        trace.delete();
        bus_if.req_valid = 1'b1;
        bus_if.req_operand = n;
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        bus_if.req_operand = '0;
        chk({tag, " busy after accept"}, 128'({bus_if.busy, bus_if.req_ready}), 128'(2'b10));
        lat = 0;
        while (!bus_if.rsp_valid && lat < 200) begin @(negedge clk); lat++; end
        chk({tag, " latency"}, 128'(lat), 128'(exp_lat));
        chk({tag, " result"}, {bus_if.rsp_result_h, bus_if.rsp_result_l}, exp_res);
`ifdef FACTO_MASTER_TIMEOUT_EN
        chk({tag, " rsp_timeout"}, 128'(bus_if.rsp_timeout), 128'(exp_to));
`endif
        for (int i = 0; i < hold; i++) begin
            bus_if.req_valid = 1'b1;
            bus_if.req_operand = 64'hBAD;
            @(negedge clk);
            chk($sformatf("%s hold%0d valid/ready", tag, i),
                128'({bus_if.rsp_valid, bus_if.req_ready}), 128'(2'b10));
            chk($sformatf("%s hold%0d result", tag, i), {bus_if.rsp_result_h, bus_if.rsp_result_l}, exp_res);
        end
        bus_if.req_valid = 1'b0;
        bus_if.rsp_ready = 1'b1;
        @(negedge clk);
        bus_if.rsp_ready = 1'b0;
        chk({tag, " after accept valid/ready/busy"},
            128'({bus_if.rsp_valid, bus_if.req_ready, bus_if.busy}), 128'(3'b010));
`ifdef FACTO_MASTER_TIMEOUT_EN
        chk({tag, " rsp_timeout cleared"}, 128'(bus_if.rsp_timeout), 128'(0));
`endif
        check_trace(tag, n, exp_to);
    endtask

    typedef struct {
        logic [63:0]  operand;
        int           irq_delay;
        int           hold;
        logic [127:0] exp_res;
        int           exp_lat;
    } vec_t;
    vec_t vecs[5];

    initial begin
        vecs[0] = '{64'd5,  3, 0,  128'd120, 10};
        vecs[1] = '{64'd0,  2, 2,  128'd1, 9};
        vecs[2] = '{64'd1,  0, 0,  128'd1, 8};
        vecs[3] = '{64'd20, 1, 10, {64'd0, 64'h21C3677C82B40000}, 8};
        vecs[4] = '{64'd21, 5, 1,  {64'd2, 64'hC5077D36B8C40000}, 12};

        bus_if.req_valid = 1'b0;
        bus_if.req_operand = '0;
        bus_if.rsp_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset bus", 128'({bus_if.m_sel, bus_if.m_wr, bus_if.m_addr}), 128'(0));
        chk("reset m_dout", 128'(bus_if.m_dout), 128'(0));
        chk("reset rsp/busy/ready", 128'({bus_if.rsp_valid, bus_if.busy, bus_if.req_ready}), 128'(3'b001));
        chk("reset results", {bus_if.rsp_result_h, bus_if.rsp_result_l}, 128'(0));
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++)
            do_op($sformatf("vec%0d", i), vecs[i].operand, vecs[i].irq_delay, vecs[i].hold,
                  vecs[i].exp_res, vecs[i].exp_lat, 1'b0);

        // Reset pulse while sitting in WAIT with a previous result still held.
        irq_delay = -1;
        bus_if.req_valid = 1'b1;
        bus_if.req_operand = 64'd9;
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid-wait busy/sel", 128'({bus_if.busy, bus_if.m_sel}), 128'(2'b10));
        #2 reset = 1'b1;
        #1;
        chk("async reset bus", 128'({bus_if.m_sel, bus_if.m_wr, bus_if.m_addr, bus_if.m_dout}), 128'(0));
        chk("async reset rsp/busy/ready", 128'({bus_if.rsp_valid, bus_if.busy, bus_if.req_ready}), 128'(3'b001));
        chk("async reset results", {bus_if.rsp_result_h, bus_if.rsp_result_l}, 128'(0));
        @(negedge clk);
        reset = 1'b0;
        do_op("after reset n=3", 64'd3, 2, 0, 128'd6, 9, 1'b0);

`ifdef FACTO_MASTER_TIMEOUT_EN
        do_op("timeout", 64'd7, -1, 2, 128'd0, 5 + TO_CYCLES + 2, 1'b1);
        do_op("after timeout", 64'd4, 0, 0, 128'd24, 8, 1'b0);
`endif

        for (int i = 0; i < 6; i++) begin
            logic [63:0] n;
            int d;
            int h;
            n = 64'($urandom_range(0, 34));
            d = int'($urandom_range(0, 5));
            h = int'($urandom_range(0, 3));
            do_op($sformatf("rand%0d n=%0d d=%0d", i, n, d), n, d, h, fact128(n), exp_latency(d), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
